// File: rtl/regfile.sv
// regfile: 32 x 32-bit general-purpose register file.
// One synchronous write port and two independent combinational read ports.
// Register 0 always reads as zero, and writes to it are dropped.
module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEn,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0]   writeDecode;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] readA;
  logic [DATA_WIDTH-1:0] readB;

  // One-hot write select, gated by the enable, with entry 0 never selected.
  always_comb begin
    // NOTE: assign a default first so every path drives the signal and no latch is inferred.
    writeDecode = '0;
    if (ctrl_writeEn) begin
      writeDecode[ctrl_writeReg] = 1'b1;
    end
    writeDecode[0] = 1'b0;
  end

  // Register storage: a synchronous clear takes priority over any write.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      // NOTE: this array is built from flops, not a RAM macro. Clearing every entry
      //       is cheap here and keeps unwritten registers free of X.
      for (int i = 0; i < NUM_REGS; i++) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (writeDecode[i]) begin
          regs[i] <= data_writeReg;
        end
      end
    end
  end

  // Read muxes: a purely combinational path. Index 0 is forced to zero. There is no
  // write bypass, so a read shows a new value only after the edge that writes it.
  always_comb begin
    readA = '0;
    readB = '0;
    if (ctrl_readRegA != '0) begin
      readA = regs[ctrl_readRegA];
    end
    if (ctrl_readRegB != '0) begin
      readB = regs[ctrl_readRegB];
    end
  end

  assign data_readRegA = readA;
  assign data_readRegB = readB;

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: checks regfile against an array model of the architectural registers.
module tb_regfile;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_writeEn;
  logic [4:0]  ctrl_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_writeReg;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [32];

  regfile dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .ctrl_writeEn  (ctrl_writeEn),
    .ctrl_writeReg (ctrl_writeReg),
    .ctrl_readRegA (ctrl_readRegA),
    .ctrl_readRegB (ctrl_readRegB),
    .data_writeReg (data_writeReg),
    .data_readRegA (data_readRegA),
    .data_readRegB (data_readRegB)
  );

  // Free-running clock with a 10-unit period.
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Apply one rising edge with the current inputs, then update the model:
  // a reset clears everything, and an enabled write to a nonzero index stores the data.
  task automatic tick();
    @(posedge clock);
    if (ctrl_reset) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (ctrl_writeEn && ctrl_writeReg != 5'd0) begin
      model[ctrl_writeReg] = data_writeReg;
    end
    #1;
  endtask

  task automatic writeReg(input logic [4:0] idx, input logic [31:0] value);
    ctrl_writeEn  = 1'b1;
    ctrl_writeReg = idx;
    data_writeReg = value;
    tick();
    ctrl_writeEn  = 1'b0;
  endtask

  task automatic readBoth(input string tag, input logic [4:0] idx);
    ctrl_readRegA = idx;
    ctrl_readRegB = idx;
    #1;
    check($sformatf("%s_A[%0d]", tag, idx), data_readRegA, model[idx]);
    check($sformatf("%s_B[%0d]", tag, idx), data_readRegB, model[idx]);
  endtask

  initial begin
    logic [4:0]  idx;
    logic [31:0] value;

    for (int i = 0; i < 32; i++) model[i] = '0;
    ctrl_reset    = 1'b1;
    ctrl_writeEn  = 1'b0;
    ctrl_writeReg = '0;
    ctrl_readRegA = '0;
    ctrl_readRegB = '0;
    data_writeReg = '0;
    #2;

    // Reset is held for two edges, then released. Every index must read zero.
    tick();
    tick();
    ctrl_reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(i);
      #1;
      check($sformatf("rst_A[%0d]", i), data_readRegA, 32'h0);
      check($sformatf("rst_B[%0d]", i), data_readRegB, 32'h0);
    end

    // Basic write and readback. A neighbouring register must stay zero.
    writeReg(5'd5, 32'hDEADBEEF);
    ctrl_readRegA = 5'd5;
    ctrl_readRegB = 5'd5;
    #1;
    check("wr5_A", data_readRegA, 32'hDEADBEEF);
    check("wr5_B", data_readRegB, 32'hDEADBEEF);
    ctrl_readRegA = 5'd6;
    #1;
    check("reg6_zero", data_readRegA, 32'h0);

    // Register 0 is hardwired to zero.
    writeReg(5'd0, 32'hFFFFFFFF);
    ctrl_readRegA = 5'd0;
    ctrl_readRegB = 5'd0;
    #1;
    check("r0_A", data_readRegA, 32'h0);
    check("r0_B", data_readRegB, 32'h0);

    // With the write enable low, the address and data inputs have no effect.
    ctrl_writeEn  = 1'b0;
    ctrl_writeReg = 5'd7;
    data_writeReg = 32'h12345678;
    repeat (3) tick();
    ctrl_readRegA = 5'd7;
    #1;
    check("wen0_r7", data_readRegA, 32'h0);

    // Read and write the same register: no bypass. The old value shows
    // before the edge, and the new value shows after it.
    ctrl_readRegA = 5'd5;
    ctrl_writeEn  = 1'b1;
    ctrl_writeReg = 5'd5;
    data_writeReg = 32'hCAFEF00D;
    #1;
    check("nobypass_old", data_readRegA, 32'hDEADBEEF);
    tick();
    ctrl_writeEn = 1'b0;
    check("nobypass_new", data_readRegA, 32'hCAFEF00D);

    // Random writes, each read back on both ports.
    for (int n = 0; n < 100; n++) begin
      idx   = 5'($urandom_range(0, 31));
      value = $urandom;
      writeReg(idx, value);
      readBoth("rand", idx);
    end

    // Dual-port independence: the two ports read different registers.
    writeReg(5'd3, 32'h33333333);
    writeReg(5'd9, 32'h99999999);
    ctrl_readRegA = 5'd3;
    ctrl_readRegB = 5'd9;
    #1;
    check("dual_A3", data_readRegA, 32'h33333333);
    check("dual_B9", data_readRegB, 32'h99999999);

    // Fill every register with nonzero data, then sweep-check it against the model.
    for (int i = 1; i < 32; i++) writeReg(5'(i), (32'(i) * 32'h01010101) | 32'h80000000);
    for (int i = 0; i < 32; i++) readBoth("fill", 5'(i));

    // Reset with a simultaneous write: reset wins and everything clears.
    ctrl_reset    = 1'b1;
    ctrl_writeEn  = 1'b1;
    ctrl_writeReg = 5'd4;
    data_writeReg = 32'hA5A5A5A5;
    tick();
    tick();
    ctrl_reset   = 1'b0;
    ctrl_writeEn = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(i);
      #1;
      check($sformatf("rst2_A[%0d]", i), data_readRegA, 32'h0);
      check($sformatf("rst2_B[%0d]", i), data_readRegB, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
